// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - shared iterative mul/div engine, HI/LO owner and two-slot scheduler
module muldiv_sched #(
   parameter int ITERS  = 32,
   parameter int NSLOTS = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NSLOTS-1:0]       req_valid,
   input  logic [NSLOTS-1:0][1:0]  req_op,
   input  logic [NSLOTS-1:0][31:0] req_a,
   input  logic [NSLOTS-1:0][31:0] req_b,
   output logic [NSLOTS-1:0]       req_ready,
   input  logic                    flush,
   input  logic                    wr_hi,
   input  logic                    wr_lo,
   input  logic [31:0]             wr_data,
   output logic [31:0]             hi,
   output logic [31:0]             lo,
   output logic                    hilo_valid,
   output logic                    busy,
   output logic                    done
);
   localparam int CW = $clog2(ITERS);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          rr_pri;
   logic          accept;
   logic          gsel;

   // acc holds {product} for multiply, {remainder, quotient} for divide
   logic [63:0]   acc;
   logic [31:0]   opnd;
   logic          is_div;
   logic          neg_lo;
   logic          neg_hi;
   logic          div0;

   logic [1:0]    sel_op;
   logic [31:0]   sel_a, sel_b, abs_a, abs_b;
   logic          sa, sb;

   logic [32:0]   mul_sum, div_sh, div_diff;
   logic [63:0]   mul_step, div_step, neg_acc;
   logic [31:0]   fix_hi, fix_lo;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      accept    = 1'b0;
      gsel      = 1'b0;
      case (state)
         IDLE: begin
            if (!flush && |req_valid) begin
               gsel            = (&req_valid) ? rr_pri : req_valid[1];
               req_ready[gsel] = 1'b1;
               accept          = 1'b1;
               state_nx        = RUN;
            end
         end
         RUN:     if (cnt == '0) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   // Ops 0 and 2 are the signed variants
   always_comb begin
      sel_op = req_op[gsel];
      sel_a  = req_a[gsel];
      sel_b  = req_b[gsel];
      sa     = ~sel_op[0] & sel_a[31];
      sb     = ~sel_op[0] & sel_b[31];
      abs_a  = sa ? (32'd0 - sel_a) : sel_a;
      abs_b  = sb ? (32'd0 - sel_b) : sel_b;
   end

   always_comb begin
      mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      mul_step = {mul_sum, acc[31:1]};
      div_sh   = acc[63:31];
      div_diff = div_sh - {1'b0, opnd};
      div_step = div_diff[32] ? {div_sh[31:0], acc[30:0], 1'b0}
                              : {div_diff[31:0], acc[30:0], 1'b1};
      neg_acc  = 64'd0 - acc;
      if (is_div) begin
         fix_lo = div0 ? 32'hFFFF_FFFF : (neg_lo ? neg_acc[31:0] : acc[31:0]);
         fix_hi = neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];
      end else begin
         {fix_hi, fix_lo} = neg_lo ? neg_acc : acc;
      end
   end

   // FIX write is placed after MTHI/MTLO so it wins a same-cycle conflict
   always_ff @(posedge clock) begin
      if (reset) begin
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         rr_pri <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         div0   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (wr_hi) hi <= wr_data;
         if (wr_lo) lo <= wr_data;
         if (accept) begin
            rr_pri <= ~gsel;
            is_div <= sel_op[1];
            opnd   <= sel_op[1] ? abs_b : abs_a;
            acc    <= {32'd0, (sel_op[1] ? abs_a : abs_b)};
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
            div0   <= sel_op[1] & (sel_b == 32'd0);
            cnt    <= CW'(ITERS - 1);
         end else if (state == RUN) begin
            acc <= is_div ? div_step : mul_step;
            cnt <= cnt - 1'b1;
         end else if (state == FIX && !flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
         end
      end
   end

   assign busy       = (state != IDLE);
   assign hilo_valid = ~busy;
endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - directed bench for muldiv_sched
module tb_muldiv_sched;
   logic             clock = 1'b0;
   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0][1:0]  req_op;
   logic [1:0][31:0] req_a;
   logic [1:0][31:0] req_b;
   logic [1:0]       req_ready;
   logic             flush;
   logic             wr_hi;
   logic             wr_lo;
   logic [31:0]      wr_data;
   logic [31:0]      hi;
   logic [31:0]      lo;
   logic             hilo_valid;
   logic             busy;
   logic             done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   muldiv_sched #(.ITERS(32), .NSLOTS(2)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .hi(hi), .lo(lo),
      .hilo_valid(hilo_valid), .busy(busy), .done(done)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      flush     = 1'b0;
      wr_hi     = 1'b0;
      wr_lo     = 1'b0;
      wr_data   = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Issues one op on slot 0 and waits for done; cyc is the cycle index of done
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
      req_op[0]    = op;
      req_a[0]     = a;
      req_b[0]     = b;
      req_valid    = 2'b01;
      #1;
      check("accept_ready", {62'd0, req_ready}, 64'd1);
      step();
      req_valid = '0;
      cyc = 1;
      while (!done && cyc < 40) begin
         step();
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      logic [1:0] exp_g;

      vecs[0] = '{2'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[1] = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[2] = '{2'd3, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF};
      vecs[3] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
      vecs[5] = '{2'd2, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[6] = '{2'd3, 32'd100,       32'd7,        32'd2,         32'd14};
      vecs[7] = '{2'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[8] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[9] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};

      do_reset();
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_hilo_valid", {63'd0, hilo_valid}, 64'd1);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_ready_idle", {62'd0, req_ready}, 64'd0);
      req_valid = 2'b11;
      #1;
      check("rst_ready_both", {62'd0, req_ready}, 64'd1);
      req_valid = 2'b10;
      #1;
      check("rst_ready_slot1", {62'd0, req_ready}, 64'd2);
      req_valid = '0;

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
         check($sformatf("vec%0d_latency", i), 64'(cyc), 64'd34);
         check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].eh});
         check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].el});
         check($sformatf("vec%0d_hilo_valid", i), {63'd0, hilo_valid}, 64'd1);
         step();
         check($sformatf("vec%0d_done_pulse", i), {63'd0, done}, 64'd0);
      end

      // Round-robin with both slots continuously requesting
      do_reset();
      req_op    = {2'd1, 2'd1};
      req_a     = {32'd5, 32'd5};
      req_b     = {32'd6, 32'd6};
      req_valid = 2'b11;
      exp_g     = 2'b01;
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rr%0d_grant", k), {62'd0, req_ready}, {62'd0, exp_g});
         step();
         if (k == 3) req_valid = '0;
         cyc = 1;
         while (!done && cyc < 40) begin
            step();
            cyc++;
         end
         check($sformatf("rr%0d_spacing", k), 64'(cyc), 64'd34);
         check($sformatf("rr%0d_lo", k), {32'd0, lo}, 64'd30);
         check($sformatf("rr%0d_hi", k), {32'd0, hi}, 64'd0);
         exp_g = ~exp_g;
      end
      check("rr_idle_after", {62'd0, req_ready}, 64'd0);

      // Flush in IDLE blocks accept, flush during RUN discards the op
      wr_hi   = 1'b1;
      wr_data = 32'h1111;
      step();
      wr_hi   = 1'b0;
      wr_lo   = 1'b1;
      wr_data = 32'h2222;
      step();
      wr_lo = 1'b0;
      req_op[0] = 2'd2;
      req_a[0]  = 32'd100;
      req_b[0]  = 32'd7;
      req_valid = 2'b01;
      flush     = 1'b1;
      #1;
      check("flush_idle_ready", {62'd0, req_ready}, 64'd0);
      step();
      flush = 1'b0;
      check("flush_idle_busy", {63'd0, busy}, 64'd0);
      #1;
      step();
      req_valid = '0;
      repeat (9) step();
      check("flush_run_busy", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_c11_busy", {63'd0, busy}, 64'd0);
      check("flush_c11_hi", {32'd0, hi}, 64'h1111);
      check("flush_c11_lo", {32'd0, lo}, 64'h2222);
      check("flush_c11_done", {63'd0, done}, 64'd0);
      run_op(2'd1, 32'd3, 32'd4, cyc);
      check("flush_next_latency", 64'(cyc), 64'd34);
      check("flush_next_lo", {32'd0, lo}, 64'd12);
      check("flush_next_hi", {32'd0, hi}, 64'd0);

      // MTHI collides with the FIX write
      req_op[0] = 2'd1;
      req_a[0]  = 32'd2;
      req_b[0]  = 32'd2;
      req_valid = 2'b01;
      step();
      req_valid = '0;
      repeat (32) step();
      check("fix_busy", {63'd0, busy}, 64'd1);
      wr_hi   = 1'b1;
      wr_data = 32'hABCD;
      step();
      wr_hi = 1'b0;
      check("conflict_done", {63'd0, done}, 64'd1);
      check("conflict_hi", {32'd0, hi}, 64'd0);
      check("conflict_lo", {32'd0, lo}, 64'd4);
      wr_lo   = 1'b1;
      wr_data = 32'h5A5A;
      step();
      wr_lo = 1'b0;
      check("mtlo_lo", {32'd0, lo}, 64'h5A5A);
      check("mtlo_hi", {32'd0, hi}, 64'd0);

      // Flush landing in FIX suppresses the write and done
      req_a[0]  = 32'd3;
      req_b[0]  = 32'd3;
      req_valid = 2'b01;
      step();
      req_valid = '0;
      repeat (32) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_fix_done", {63'd0, done}, 64'd0);
      check("flush_fix_lo", {32'd0, lo}, 64'h5A5A);
      check("flush_fix_busy", {63'd0, busy}, 64'd0);

      // Reset mid-RUN after a slot-0 grant moved the pointer to slot 1
      req_a[0]  = 32'd2;
      req_b[0]  = 32'd3;
      req_valid = 2'b01;
      step();
      req_valid = '0;
      repeat (4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rrun_busy", {63'd0, busy}, 64'd0);
      check("rrun_hilo_valid", {63'd0, hilo_valid}, 64'd1);
      check("rrun_hi", {32'd0, hi}, 64'd0);
      check("rrun_lo", {32'd0, lo}, 64'd0);
      check("rrun_done", {63'd0, done}, 64'd0);
      req_valid = 2'b11;
      #1;
      check("rrun_ready_both", {62'd0, req_ready}, 64'd1);
      req_valid = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
